// File: rtl/activity_pkg.sv
// Shared definitions for the activity detector.
// Contents:
//   state_e          - pulse FSM states (idle / holdoff)
//   EDGE_COUNT_W     - width of the free-running qualified-edge counter
//   HOLDOFF_DEFAULT  - default pulse holdoff window in clocks
package activity_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StHoldoff
  } state_e;

  localparam int unsigned EDGE_COUNT_W    = 16;
  localparam logic [31:0] HOLDOFF_DEFAULT = 32'd1_000;

endpackage

// File: rtl/activity_detector_sync_filter.sv
// Synchroniser plus glitch filter for an asynchronous, idle-high line.
// Ports:
//   clk           - system clock
//   reset         - asynchronous active-high reset
//   line_in       - raw asynchronous line
//   level         - filtered, synchronised line level (registered)
//   level_changed - high in the cycle whose closing edge updates level
//   level_rising  - direction of that update (1 = 0->1), valid with level_changed
module sync_filter #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic level_changed,
  output logic level_rising
);

  localparam int unsigned CntW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(FILTER_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CntW-1:0]        filt_q, filt_d;
  logic                   level_q, level_d;

  // Reset to the idle-high state so release does not look like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    filt_d        = '0;
    level_d       = level_q;
    level_changed = 1'b0;
    if (sync != level_q) begin
      if (filt_q == LastCnt) begin
        level_d       = sync;
        level_changed = 1'b1;
      end else begin
        filt_d = filt_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q  <= '0;
      level_q <= 1'b1;
    end else begin
      filt_q  <= filt_d;
      level_q <= level_d;
    end
  end

  assign level        = level_q;
  assign level_rising = sync;

endmodule

// File: rtl/activity_detector.sv
// Activity detector: turns an asynchronous line into rate-limited one-cycle
// activity pulses and keeps a wrapping count of qualified edges.
// Optional feature macro: ACTIVITY_BOTH_EDGES_EN (defined: rising and falling
// level updates qualify; undefined: falling only).
// Ports:
//   clk        - system clock
//   reset      - asynchronous active-high reset
//   line_in    - asynchronous monitored line, idle high
//   enable     - synchronous enable for pulse generation and counting
//   activity   - registered one-cycle pulse per qualified edge
//   level      - filtered, synchronised line level
//   edge_count - count of qualified edges, wraps
module activity_detector
  import activity_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_CYCLES  = 4,
  parameter logic [31:0] HOLDOFF_CYCLES = HOLDOFF_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    line_in,
  input  logic                    enable,
  output logic                    activity,
  output logic                    level,
  output logic [EDGE_COUNT_W-1:0] edge_count
);

  localparam logic [EDGE_COUNT_W-1:0] CountOne = EDGE_COUNT_W'(1);

  logic level_changed;
  logic level_rising;
  logic qualified;

  state_e                  state_q, state_d;
  logic [31:0]             hold_q, hold_d;
  logic [EDGE_COUNT_W-1:0] count_q, count_d;
  logic                    activity_q, activity_d;

  sync_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_sync_filter (
    .clk          (clk),
    .reset        (reset),
    .line_in      (line_in),
    .level        (level),
    .level_changed(level_changed),
    .level_rising (level_rising)
  );

  // The strobe precedes the level update by one cycle, so registering the
  // pulse here makes activity and level change on the same edge.
`ifdef ACTIVITY_BOTH_EDGES_EN
  assign qualified = level_changed;
`else
  assign qualified = level_changed & ~level_rising;
`endif

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    count_d    = count_q;
    activity_d = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      hold_d  = '0;
    end else begin
      if (qualified) begin
        count_d = count_q + CountOne;
      end
      unique case (state_q)
        StIdle: begin
          if (qualified) begin
            activity_d = 1'b1;
            if (HOLDOFF_CYCLES != 32'd0) begin
              hold_d  = HOLDOFF_CYCLES - 32'd1;
              state_d = StHoldoff;
            end
          end
        end
        StHoldoff: begin
          // An edge arriving while hold is 0 is counted above but not pulsed.
          if (hold_q == 32'd0) begin
            state_d = StIdle;
          end else begin
            hold_d = hold_q - 32'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      count_q    <= '0;
      activity_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      count_q    <= count_d;
      activity_q <= activity_d;
    end
  end

  assign activity   = activity_q;
  assign edge_count = count_q;

endmodule

// File: tb/tb_activity_detector.sv
// Directed testbench for activity_detector.
// Instances: u_a (defaults, holdoff 1000), u_b (holdoff 20) share clk and
// stimulus; u_w (filter 1, holdoff 0) runs on a fast clock for the wrap test.
`timescale 1ns / 100ps
module tb_activity_detector;

  logic clk   = 1'b0;
  logic clk_w = 1'b0;
  logic reset, reset_w;
  logic line, line_w, enable;

  logic        act_a, level_a, act_b, level_b, act_w, level_w;
  logic [15:0] cnt_a, cnt_b, cnt_w;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  always #5 clk = ~clk;
  always #1 clk_w = ~clk_w;

  activity_detector u_a (
    .clk       (clk),
    .reset     (reset),
    .line_in   (line),
    .enable    (enable),
    .activity  (act_a),
    .level     (level_a),
    .edge_count(cnt_a)
  );

  activity_detector #(
    .HOLDOFF_CYCLES(32'd20)
  ) u_b (
    .clk       (clk),
    .reset     (reset),
    .line_in   (line),
    .enable    (enable),
    .activity  (act_b),
    .level     (level_b),
    .edge_count(cnt_b)
  );

  activity_detector #(
    .SYNC_STAGES   (2),
    .FILTER_CYCLES (1),
    .HOLDOFF_CYCLES(32'd0)
  ) u_w (
    .clk       (clk_w),
    .reset     (reset_w),
    .line_in   (line_w),
    .enable    (1'b1),
    .activity  (act_w),
    .level     (level_w),
    .edge_count(cnt_w)
  );

  // Total high cycles of each pulse output, to catch extra or widened pulses.
  always @(negedge clk) begin
    if (act_a === 1'b1) pulses_a++;
    if (act_b === 1'b1) pulses_b++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic tickw();
    @(posedge clk_w);
    #0.5;
  endtask

  initial begin
    reset   = 1'b1;
    reset_w = 1'b1;
    line    = 1'b1;
    line_w  = 1'b1;
    enable  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;

`ifndef ACTIVITY_BOTH_EDGES_EN
    check("rst_level", {31'd0, level_a}, 32'd1);
    check("rst_act", {31'd0, act_a}, 32'd0);
    check("rst_cnt_a", {16'd0, cnt_a}, 32'd0);
    check("rst_cnt_b", {16'd0, cnt_b}, 32'd0);

    // Falling step at 10 -> level/pulse at 16.
    wait_to(10); line = 1'b0;
    wait_to(15);
    check("lat_level_pre", {31'd0, level_a}, 32'd1);
    check("lat_act_pre", {31'd0, act_a}, 32'd0);
    wait_to(16);
    check("lat_level", {31'd0, level_a}, 32'd0);
    check("lat_act", {31'd0, act_a}, 32'd1);
    check("lat_cnt_a", {16'd0, cnt_a}, 32'd1);
    check("lat_act_b", {31'd0, act_b}, 32'd1);
    check("lat_cnt_b", {16'd0, cnt_b}, 32'd1);
    line = 1'b1;
    wait_to(17);
    check("pulse_width", {31'd0, act_a}, 32'd0);

    // Second fall 10 cycles later lands inside u_b's holdoff.
    wait_to(20); line = 1'b0;
    wait_to(26);
    check("hold_level_b", {31'd0, level_b}, 32'd0);
    check("hold_act_b", {31'd0, act_b}, 32'd0);
    check("hold_cnt_b", {16'd0, cnt_b}, 32'd2);
    check("hold_cnt_a", {16'd0, cnt_a}, 32'd2);
    line = 1'b1;

    // Third fall 30 cycles after the second: u_b idle again, u_a still holding.
    wait_to(50); line = 1'b0;
    wait_to(56);
    check("rearm_act_b", {31'd0, act_b}, 32'd1);
    check("rearm_cnt_b", {16'd0, cnt_b}, 32'd3);
    check("rearm_act_a", {31'd0, act_a}, 32'd0);
    check("rearm_cnt_a", {16'd0, cnt_a}, 32'd3);
    line = 1'b1;

    // 3-cycle glitch rejected.
    wait_to(70); line = 1'b0;
    wait_to(73); line = 1'b1;
    wait_to(79);
    check("glitch_level", {31'd0, level_a}, 32'd1);
    check("glitch_cnt_a", {16'd0, cnt_a}, 32'd3);
    check("glitch_cnt_b", {16'd0, cnt_b}, 32'd3);

    // 4-cycle low accepted.
    wait_to(80); line = 1'b0;
    wait_to(84); line = 1'b1;
    wait_to(86);
    check("low4_level", {31'd0, level_a}, 32'd0);
    check("low4_act_b", {31'd0, act_b}, 32'd1);
    check("low4_cnt_b", {16'd0, cnt_b}, 32'd4);
    check("low4_cnt_a", {16'd0, cnt_a}, 32'd4);

    // Edge with enable low: level follows, no pulse, count frozen.
    wait_to(95); enable = 1'b0; line = 1'b0;
    wait_to(101);
    check("dis_level", {31'd0, level_a}, 32'd0);
    check("dis_act_b", {31'd0, act_b}, 32'd0);
    check("dis_cnt_b", {16'd0, cnt_b}, 32'd4);
    check("dis_cnt_a", {16'd0, cnt_a}, 32'd4);
    enable = 1'b1; line = 1'b1;

    // Disable cleared u_a's long holdoff, so it pulses again.
    wait_to(110); line = 1'b0;
    wait_to(116);
    check("reen_act_a", {31'd0, act_a}, 32'd1);
    check("reen_cnt_a", {16'd0, cnt_a}, 32'd5);
    check("reen_act_b", {31'd0, act_b}, 32'd1);
    check("reen_cnt_b", {16'd0, cnt_b}, 32'd5);

    // Reset mid-holdoff with line held low.
    wait_to(118); reset = 1'b1;
    #1;
    check("mid_rst_cnt_a", {16'd0, cnt_a}, 32'd0);
    check("mid_rst_cnt_b", {16'd0, cnt_b}, 32'd0);
    check("mid_rst_level", {31'd0, level_a}, 32'd1);
    wait_to(119); reset = 1'b0;
    wait_to(124);
    check("post_rst_act_pre", {31'd0, act_a}, 32'd0);
    wait_to(125);
    check("post_rst_act_a", {31'd0, act_a}, 32'd1);
    check("post_rst_cnt_a", {16'd0, cnt_a}, 32'd1);
    check("post_rst_cnt_b", {16'd0, cnt_b}, 32'd1);
    check("post_rst_level", {31'd0, level_a}, 32'd0);
    wait_to(130);
    check("pulses_a", pulses_a, 32'd3);
    check("pulses_b", pulses_b, 32'd5);

    // Wrap: 65535 edges reach FFFF, one more wraps to 0.
    tickw();
    reset_w = 1'b0;
    tickw();
    check("w_rst_cnt", {16'd0, cnt_w}, 32'd0);
    for (int i = 0; i < 65535; i++) begin
      line_w = 1'b0;
      tickw();
      line_w = 1'b1;
      tickw();
    end
    repeat (6) tickw();
    check("w_full", {16'd0, cnt_w}, 32'h0000_ffff);
    line_w = 1'b0;
    tickw();
    line_w = 1'b1;
    repeat (6) tickw();
    check("w_wrap", {16'd0, cnt_w}, 32'd0);
`else
    // Both edges: a 10-cycle low gives two pulses 10 cycles apart.
    tickw();
    reset_w = 1'b0;
    tickw();
    check("be_rst_cnt", {16'd0, cnt_w}, 32'd0);
    line_w = 1'b0;
    repeat (2) tickw();
    check("be_fall_pre", {31'd0, act_w}, 32'd0);
    tickw();
    check("be_fall_act", {31'd0, act_w}, 32'd1);
    check("be_fall_level", {31'd0, level_w}, 32'd0);
    repeat (7) tickw();
    line_w = 1'b1;
    repeat (2) tickw();
    check("be_rise_pre", {31'd0, act_w}, 32'd0);
    tickw();
    check("be_rise_act", {31'd0, act_w}, 32'd1);
    check("be_rise_level", {31'd0, level_w}, 32'd1);
    check("be_cnt", {16'd0, cnt_w}, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
